// File: rtl/clock_step_controller.sv
// clock_step_controller: run / halt / single-step clock-enable generator
// with a power-of-two period that only changes on period boundaries.
module clock_step_controller #(
    parameter int CNT_W    = 16,
    parameter int CE_CNT_W = 32
) (
    input  logic                in_clk,
    input  logic                rst_n,
    input  logic                run_req,
    input  logic                step_req,
    input  logic [15:0]         divider_factor,
    input  logic                factor_load,
    output logic                cpu_ce,
    output logic                step_done,
    output logic [1:0]          state,
    output logic [3:0]          active_factor,
    output logic [CE_CNT_W-1:0] ce_count
);
    localparam int MAX_F = (CNT_W - 1 > 15) ? 15 : CNT_W - 1;

    typedef enum logic [1:0] {
        S_HALT  = 2'b00,
        S_RUN   = 2'b01,
        S_STEP  = 2'b10,
        S_DRAIN = 2'b11
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [3:0]          r_pending;
    logic [3:0]          r_active;
    logic [CE_CNT_W-1:0] r_ce_count;

    logic                w_busy;
    logic                w_last;
    logic                w_ce;
    logic [CNT_W-1:0]    w_last_cnt;
    logic [CNT_W-1:0]    w_cnt_next;
    logic [3:0]          w_load_val;
    logic [3:0]          w_next_pending;

    assign w_load_val     = (divider_factor > 16'(MAX_F)) ? 4'(MAX_F)
                                                          : divider_factor[3:0];
    assign w_next_pending = factor_load ? w_load_val : r_pending;

    // Terminal count of the current period: 2^active - 1.
    assign w_last_cnt = (CNT_W'(1) << r_active) - CNT_W'(1);
    assign w_busy     = (r_state != S_HALT);
    assign w_last     = (r_cnt == w_last_cnt);
    assign w_ce       = w_busy && w_last;
    assign w_cnt_next = w_last ? '0 : r_cnt + CNT_W'(1);

    always_ff @(posedge in_clk) begin
        if (!rst_n) begin
            r_state    <= S_HALT;
            r_cnt      <= '0;
            r_pending  <= '0;
            r_active   <= '0;
            r_ce_count <= '0;
        end else begin
            r_pending <= w_next_pending;
            // A fresh load on a boundary cycle takes effect at that boundary.
            if (r_state == S_HALT || w_ce)
                r_active <= w_next_pending;
            if (w_ce)
                r_ce_count <= r_ce_count + CE_CNT_W'(1);

            unique case (r_state)
                S_HALT: begin
                    r_cnt <= '0;
                    if (run_req)
                        r_state <= S_RUN;
                    else if (step_req)
                        r_state <= S_STEP;
                end
                S_RUN: begin
                    r_cnt <= w_cnt_next;
                    if (!run_req)
                        r_state <= w_last ? S_HALT : S_DRAIN;
                end
                S_STEP: begin
                    r_cnt <= w_cnt_next;
                    if (w_last)
                        r_state <= S_HALT;
                end
                S_DRAIN: begin
                    r_cnt <= w_cnt_next;
                    if (run_req)
                        r_state <= S_RUN;
                    else if (w_last)
                        r_state <= S_HALT;
                end
            endcase
        end
    end

    assign cpu_ce        = w_ce;
    assign step_done     = w_ce && (r_state == S_STEP);
    assign state         = r_state;
    assign active_factor = r_active;
    assign ce_count      = r_ce_count;

endmodule

// File: doc/clock_step_controller.md
CLOCK_STEP_CONTROLLER -- requirements
Module: clock_step_controller

Interface
REQ-001 SHALL have parameter CNT_W, default 16, meaning the width of the period counter (supports factors 0..CNT_W-1).
REQ-002 SHALL have parameter CE_CNT_W, default 32, meaning the width of the issued-enable counter.
REQ-003 SHALL have port in_clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset that is synchronous and active-low.
REQ-005 SHALL have port run_req, input, 1, level: 1 = free-run the processor, 0 = halt.
REQ-006 SHALL have port step_req, input, 1, single-cycle pulse requesting one processor step.
REQ-007 SHALL have port divider_factor, input, 16, requested rate exponent; period P = 2^factor in_clk cycles.
REQ-008 SHALL have port factor_load, input, 1, single-cycle pulse capturing divider_factor.
REQ-009 SHALL have port cpu_ce, output, 1, processor clock-enable pulse, one in_clk cycle wide.
REQ-010 SHALL have port step_done, output, 1, single-cycle pulse coincident with the cpu_ce of a step.
REQ-011 SHALL have port state, output, 2, current state: 00 HALT, 01 RUN, 10 STEP, 11 DRAIN.
REQ-012 SHALL have port active_factor, output, 4, the factor currently governing P.
REQ-013 SHALL have port ce_count, output, CE_CNT_W, total cpu_ce pulses issued.

Function
REQ-014 SHALL keep a registered pending_factor; on factor_load it SHALL capture min(divider_factor, CNT_W-1), saturating values above 15 to 15.
REQ-015 SHALL copy pending_factor into active_factor only in HALT or on a cycle where cpu_ce=1, so P never changes mid-period.
REQ-016 SHALL, when factor_load and a cpu_ce cycle coincide, apply the newly captured value at that same boundary.
REQ-017 SHALL keep period counter cnt (CNT_W bits): cleared on every entry to RUN or STEP; increments each cycle in RUN/STEP/DRAIN; wraps to 0 on the cycle after cnt==P-1.
REQ-018 SHALL decode cpu_ce = (state in RUN, STEP, DRAIN) and cnt==P-1, from registered state only (no input-to-output combinational path).
REQ-019 SHALL, for active_factor=0 (P=1), assert cpu_ce on every cycle spent in RUN.
REQ-020 SHALL implement these transitions: HALT->RUN when run_req=1; HALT->STEP when run_req=0 and step_req=1; run_req wins when both are high.
REQ-021 SHALL implement RUN->DRAIN when run_req=0 and cnt!=P-1; RUN->HALT when run_req=0 and cnt==P-1 (the pulse is still issued).
REQ-022 SHALL in DRAIN finish the current period, issue its cpu_ce, then go to HALT; run_req reasserted during DRAIN SHALL return to RUN without clearing cnt.
REQ-023 SHALL in STEP issue exactly one cpu_ce at cnt==P-1 with step_done=1 in the same cycle, then go to HALT.
REQ-024 SHALL ignore step_req outside HALT; run_req during STEP SHALL be honoured only after the return to HALT.
REQ-025 SHALL place the first cpu_ce after entering RUN/STEP exactly P cycles after the entry edge, counting the entry cycle as cycle 1.
REQ-026 SHALL increment ce_count on every cpu_ce, wrapping modulo 2^CE_CNT_W.

Reset
REQ-027 SHALL, on the rising in_clk edge with rst_n=0: state=HALT, cnt=0, active_factor=0, pending_factor=0, ce_count=0; cpu_ce=0 and step_done=0 in the following cycle.
REQ-028 SHALL let reset override all inputs, including mid-period in RUN/STEP/DRAIN; no cpu_ce or step_done is issued in the cycle after reset.

Verification
REQ-029 SHALL check: reset, factor_load with factor=2, run_req=1 -> cpu_ce on every 4th cycle, first on the 4th RUN cycle; ce_count increments by 1 per pulse.
REQ-030 SHALL check: in RUN with factor 3, load factor 1 at cnt=2 -> remaining pulses of current 8-cycle period unchanged, then period 2; active_factor changes on the pulse cycle.
REQ-031 SHALL check: HALT with factor 4, step_req pulse -> STEP, one cpu_ce plus step_done 16 cycles later, back to HALT, ce_count=1; a second step_req during STEP is ignored.
REQ-032 SHALL check: factor 0, run_req=1 for 5 cycles then 0 -> 5 consecutive cpu_ce, then HALT with no DRAIN state.
REQ-033 SHALL check: factor 3, drop run_req at cnt=2 -> DRAIN, one cpu_ce at cnt=7, then HALT; repeat with rst_n=0 at cnt=5 -> HALT, no pulse, all counters 0.
REQ-034 SHALL check: divider_factor=40 loaded -> active_factor=15; run_req=1 and step_req=1 simultaneously in HALT -> RUN.
